// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle RV32M execute unit that sits beside ex.
// Handles MUL/MULH/MULHSU/MULHU with a shift-add engine and
// DIV/DIVU/REM/REMU with a restoring divider. Both engines share one
// 2*XLEN work register. The engine retires UNROLL bits per cycle.
//
// Operands are reduced to magnitudes when the op is accepted. The
// result sign is recorded at the same time and applied once at the end.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   start_i       request pulse, accepted only while idle
//   func3_i       RV32M operation select
//   op1_i, op2_i  rs1 / rs2 values
//   rd_addr_i     destination register
//   flush_i       abort the in-flight op (taken jump)
//   rd_data_o     result, meaningful while rd_wen_o=1
//   rd_addr_o     destination of the result
//   rd_wen_o      one-cycle write strobe
//   busy_o        unit not idle
//   hold_flag_o   pipeline stall request to ctrl
module ex_muldiv #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_wen_o,
  output logic            busy_o,
  output logic            hold_flag_o
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     count_reg;
  logic [2:0]        func3_reg;
  logic [4:0]        rd_addr_reg;
  logic [XLEN-1:0]   op1_reg, op2_reg;
  logic              neg_reg;
  logic [2*XLEN-1:0] work_reg;
  logic [XLEN-1:0]   rd_data_reg;
  logic [4:0]        rd_addr_out_reg;

  // Request decode. The signed views are MULH, MULHSU (op1 only),
  // DIV and REM.
  logic            is_div, sgn1, sgn2, neg1, neg2, res_neg;
  logic            div_zero, div_ovf, fast, accept, last;
  logic [XLEN-1:0] abs1, abs2, fast_data;

  always_comb begin
    is_div    = func3_i[2];
    sgn1      = (func3_i == 3'b001) || (func3_i == 3'b010) || (func3_i[2] && !func3_i[0]);
    sgn2      = (func3_i == 3'b001) || (func3_i[2] && !func3_i[0]);
    neg1      = sgn1 && op1_i[XLEN-1];
    neg2      = sgn2 && op2_i[XLEN-1];
    abs1      = neg1 ? -op1_i : op1_i;
    abs2      = neg2 ? -op2_i : op2_i;
    // A remainder takes the dividend's sign. Everything else takes the
    // sign of the product or quotient.
    res_neg   = (func3_i[2] && func3_i[1]) ? neg1 : (neg1 ^ neg2);
    div_zero  = (op2_i == '0);
    div_ovf   = sgn2 && is_div && (op1_i == INT_MIN) && (op2_i == '1);
    fast      = is_div && (div_zero || div_ovf);
    if (div_zero) fast_data = func3_i[1] ? op1_i : '1;
    else          fast_data = func3_i[1] ? '0 : INT_MIN;
    accept    = (state_reg == IDLE) && start_i && !flush_i;
    last      = (count_reg == CW'(N - 1));
  end

  // Unrolled iteration chain. Each stage retires one bit of the multiply
  // or divide, and the op latched in func3_reg selects which one.
  genvar gi;
  for (gi = 0; gi < UNROLL; gi++) begin : g_step
    logic [2*XLEN-1:0] step_in, step_out, mul_out, div_out;
    logic [XLEN:0]     sum, rem_sh;
    logic [XLEN-1:0]   diff, new_rem;
    logic              ge;

    if (gi == 0) begin : g_first
      assign step_in = work_reg;
    end else begin : g_next
      assign step_in = g_step[gi-1].step_out;
    end

    // Shift-add: the high half accumulates the multiplicand. The low
    // half shifts the multiplier out while product bits shift in.
    assign sum     = {1'b0, step_in[2*XLEN-1:XLEN]} + (step_in[0] ? {1'b0, op1_reg} : '0);
    assign mul_out = {sum, step_in[XLEN-1:1]};

    // Restoring divide: the high half is the partial remainder. The low
    // half shifts the dividend out while quotient bits shift in.
    assign rem_sh  = step_in[2*XLEN-1:XLEN-1];
    assign ge      = (rem_sh >= {1'b0, op2_reg});
    assign diff    = rem_sh[XLEN-1:0] - op2_reg;
    assign new_rem = ge ? diff : rem_sh[XLEN-1:0];
    assign div_out = {new_rem, step_in[XLEN-2:0], ge};

    assign step_out = func3_reg[2] ? div_out : mul_out;
  end

  // Final sign correction, taken from the last iteration's output.
  logic [2*XLEN-1:0] fin, mul_fix;
  logic [XLEN-1:0]   div_pick, div_fix, calc_data;

  always_comb begin
    fin      = g_step[UNROLL-1].step_out;
    mul_fix  = neg_reg ? -fin : fin;
    div_pick = func3_reg[1] ? fin[2*XLEN-1:XLEN] : fin[XLEN-1:0];
    div_fix  = neg_reg ? -div_pick : div_pick;
    if (func3_reg[2])              calc_data = div_fix;
    else if (func3_reg[1:0] == '0) calc_data = mul_fix[XLEN-1:0];
    else                           calc_data = mul_fix[2*XLEN-1:XLEN];
  end

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = fast ? DONE : CALC;
      CALC:    if (flush_i) state_next = IDLE;
               else if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg       <= '0;
      func3_reg       <= '0;
      rd_addr_reg     <= '0;
      op1_reg         <= '0;
      op2_reg         <= '0;
      neg_reg         <= 1'b0;
      work_reg        <= '0;
      rd_data_reg     <= '0;
      rd_addr_out_reg <= '0;
    end else if (accept) begin
      count_reg   <= '0;
      func3_reg   <= func3_i;
      rd_addr_reg <= rd_addr_i;
      op1_reg     <= abs1;
      op2_reg     <= abs2;
      neg_reg     <= res_neg;
      work_reg    <= {{XLEN{1'b0}}, (is_div ? abs1 : abs2)};
      if (fast) begin
        rd_data_reg     <= fast_data;
        rd_addr_out_reg <= rd_addr_i;
      end
    end else if (state_reg == CALC && !flush_i) begin
      work_reg  <= fin;
      count_reg <= count_reg + 1'b1;
      if (last) begin
        rd_data_reg     <= calc_data;
        rd_addr_out_reg <= rd_addr_reg;
      end
    end
  end

  // Hold drops in DONE so the next instruction issues as the write
  // lands. A flush in DONE suppresses the write.
  assign rd_data_o   = rd_data_reg;
  assign rd_addr_o   = rd_addr_out_reg;
  assign rd_wen_o    = (state_reg == DONE) && !flush_i;
  assign busy_o      = (state_reg != IDLE);
  assign hold_flag_o = accept || (state_reg == CALC);

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst, start_i, flush_i;
  logic [2:0]  func3_i;
  logic [31:0] op1_i, op2_i;
  logic [4:0]  rd_addr_i;

  logic [31:0] rd_data1, rd_data4;
  logic [4:0]  rd_addr1, rd_addr4;
  logic        wen1, wen4, busy1, busy4, hold1, hold4;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];

  ex_muldiv #(.XLEN(32), .UNROLL(1)) u1 (
    .clk(clk), .rst(rst), .start_i(start_i), .func3_i(func3_i),
    .op1_i(op1_i), .op2_i(op2_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
    .rd_data_o(rd_data1), .rd_addr_o(rd_addr1), .rd_wen_o(wen1),
    .busy_o(busy1), .hold_flag_o(hold1)
  );

  ex_muldiv #(.XLEN(32), .UNROLL(4)) u4 (
    .clk(clk), .rst(rst), .start_i(start_i), .func3_i(func3_i),
    .op1_i(op1_i), .op2_i(op2_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
    .rd_data_o(rd_data4), .rd_addr_o(rd_addr4), .rd_wen_o(wen4),
    .busy_o(busy4), .hold_flag_o(hold4)
  );

  // Reference model: plain 64-bit arithmetic on the RV32M definitions.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic check_txn(input int u, input exp_t e, input logic [31:0] d, input logic [4:0] rd);
    tests++;
    if (d !== e.data || rd !== e.rd || cyc != e.cyc) begin
      fails++;
      $display("FAIL txn_u%0d: data=%h rd=%0d cyc=%0d, expected data=%h rd=%0d cyc=%0d",
               u, d, rd, cyc, e.data, e.rd, e.cyc);
    end else begin
      $display("[TB] txn u%0d: data=%h rd=%0d cyc=%0d ok", u, d, rd, cyc);
    end
  endtask

  // Monitor: pops and compares whenever either unit strobes a write.
  always @(negedge clk) begin
    exp_t e;
    if (wen1) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_write_u1: data=%h rd=%0d cyc=%0d, expected no write", rd_data1, rd_addr1, cyc);
      end else begin
        e = q1.pop_front();
        check_txn(1, e, rd_data1, rd_addr1);
      end
    end
    if (wen4) begin
      if (q4.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_write_u4: data=%h rd=%0d cyc=%0d, expected no write", rd_data4, rd_addr4, cyc);
      end else begin
        e = q4.pop_front();
        check_txn(4, e, rd_data4, rd_addr4);
      end
    end
  end

  // Drives a start in the current cycle and queues the expected writes.
  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] expv, input bit p1, input bit p4);
    exp_t e;
    start_i   = 1'b1;
    func3_i   = f;
    op1_i     = a;
    op2_i     = b;
    rd_addr_i = rd;
    e.data = expv;
    e.rd   = rd;
    if (p1) begin e.cyc = cyc + (is_fast(f, a, b) ? 1 : 33); q1.push_back(e); end
    if (p4) begin e.cyc = cyc + (is_fast(f, a, b) ? 1 : 9);  q4.push_back(e); end
  endtask

  task automatic wait_done();
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (q1.size() == 0 && q4.size() == 0 && !busy1 && !busy4) return;
      @(negedge clk);
    end
    tests++; fails++;
    $display("FAIL timeout: pending u1=%0d u4=%0d, expected 0", q1.size(), q4.size());
    q1.delete();
    q4.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_u1"}, rd_data1, 32'h0);
    check({tag, "_data_u4"}, rd_data4, 32'h0);
    check({tag, "_addr_u1"}, 32'(rd_addr1), 32'h0);
    check({tag, "_addr_u4"}, 32'(rd_addr4), 32'h0);
    check({tag, "_flags_u1"}, {29'b0, wen1, busy1, hold1}, 32'h0);
    check({tag, "_flags_u4"}, {29'b0, wen4, busy4, hold4}, 32'h0);
  endtask

  // Directed vectors: func3, op1, op2, expected result.
  localparam int ND = 12;
  logic [2:0]  d_f [ND] = '{3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd7, 3'd4, 3'd6, 3'd1, 3'd2, 3'd3, 3'd6};
  logic [31:0] d_a [ND] = '{32'd100, 32'd100, 32'hFFFFFF9C, 32'hFFFFFF9C, 32'h00001234, 32'd5,
                            32'h80000000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFF9C};
  logic [31:0] d_b [ND] = '{32'd7, 32'd7, 32'd7, 32'd7, 32'd0, 32'd0,
                            32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
  logic [31:0] d_e [ND] = '{32'd14, 32'd2, 32'hFFFFFFF2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd5,
                            32'h80000000, 32'h0, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFF9C};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int t0, bad1, bad4;
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  rd;

    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
    func3_i = '0; op1_i = '0; op2_i = '0; rd_addr_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("reset");

    // MUL latency and hold window.
    @(negedge clk);
    t0 = cyc;
    launch(3'd0, 32'd7, 32'hFFFFFFFD, 5'd3, 32'hFFFFFFEB, 1, 1);
    #1;
    check("hold_at_T_u1", 32'(hold1), 32'd1);
    check("hold_at_T_u4", 32'(hold4), 32'd1);
    bad1 = 0; bad4 = 0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      #1;
      if (hold1 !== (k <= 32)) bad1++;
      if (hold4 !== (k <= 8))  bad4++;
    end
    check("hold_window_u1_errors", 32'(bad1), 32'd0);
    check("hold_window_u4_errors", 32'(bad4), 32'd0);
    wait_done();

    // Directed spec vectors.
    for (int i = 0; i < ND; i++) begin
      @(negedge clk);
      launch(d_f[i], d_a[i], d_b[i], 5'(i + 1), d_e[i], 1, 1);
      wait_done();
    end

    // Flush of a DIV at T+10; the UNROLL=4 unit has already finished by then.
    @(negedge clk);
    t0 = cyc;
    launch(3'd4, 32'd1000, 32'd3, 5'd9, 32'd333, 0, 1);
    @(negedge clk);
    start_i = 1'b0;
    while (cyc < t0 + 10) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("flush_idle_u1", 32'(busy1), 32'd0);
    check("flush_cycle", 32'(cyc), 32'(t0 + 11));
    launch(3'd5, 32'd500, 32'd9, 5'd10, 32'd55, 1, 1);
    wait_done();

    // Start together with flush while idle is dropped.
    @(negedge clk);
    launch(3'd0, 32'd3, 32'd4, 5'd11, 32'd12, 0, 0);
    flush_i = 1'b1;
    #1;
    check("flush_start_hold_u1", 32'(hold1), 32'd0);
    check("flush_start_hold_u4", 32'(hold4), 32'd0);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    check("flush_start_busy", {30'b0, busy1, busy4}, 32'd0);

    // Reset at T+5 aborts both units.
    @(negedge clk);
    t0 = cyc;
    launch(3'd6, 32'd12345, 32'd77, 5'd12, 32'd25, 0, 0);
    @(negedge clk);
    start_i = 1'b0;
    while (cyc < t0 + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    launch(3'd6, 32'd12345, 32'd77, 5'd12, 32'd25, 1, 1);
    wait_done();

    // start_i held for three cycles yields exactly one result per unit.
    @(negedge clk);
    launch(3'd3, 32'h12345678, 32'h9ABCDEF0, 5'd13, ref_result(3'd3, 32'h12345678, 32'h9ABCDEF0), 1, 1);
    repeat (2) @(negedge clk);
    wait_done();

    // Randomized operations.
    for (int n = 0; n < 60; n++) begin
      f  = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom);
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = 32'($urandom_range(0, 1000)); b = 32'($urandom_range(1, 50)); end
        3: b = 32'($urandom_range(1, 16));
        4: a = 32'h80000000;
        default: ;
      endcase
      @(negedge clk);
      launch(f, a, b, rd, ref_result(f, a, b), 1, 1);
      wait_done();
    end

    repeat (5) @(negedge clk);
    check("leftover_expected", 32'(q1.size() + q4.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
